// File: rtl/cal_adder_tree_acc.sv
// Pipelined signed adder tree over N_CH*TAPS products, with frame accumulation
// framed by first/last flags and a saturating (or truncating) output stage.
module cal_adder_tree_acc #(
    parameter int N_CH   = 4,
    parameter int TAPS   = 9,
    parameter int DIN_W  = 16,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 18,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH*TAPS*DIN_W-1:0]    din,
    input  logic                          din_valid,
    input  logic                          din_first,
    input  logic                          din_last,
    output logic signed [OUT_W-1:0]       dout,
    output logic                          dout_valid,
    output logic                          sat_flag
);

    localparam int NUM    = N_CH * TAPS;
    localparam int D      = $clog2(NUM);
    localparam int TREE_W = DIN_W + D;
    localparam int HALF   = (NUM + 1) / 2;

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // One spare slot per level so the pairwise index 2*i+1 never leaves the array.
    logic signed [TREE_W-1:0] lvl_s  [0:D][0:NUM];
    logic signed [TREE_W-1:0] node_d [1:D][0:NUM];
    logic signed [TREE_W-1:0] node_q [1:D][0:NUM];

    logic [D:1] vld_d, vld_q, fst_d, fst_q, lst_d, lst_q;

    logic signed [ACC_W-1:0] acc_d, acc_q, fin_d, fin_q, acc_sum_s;
    logic                    fin_vld_d, fin_vld_q;

    logic signed [OUT_W-1:0] dout_d, dout_q;
    logic                    dout_valid_d, dout_valid_q;
    logic                    sat_d, sat_q;

    // Level view: level 0 is the sign-extended input, higher levels are tree registers.
    always_comb begin
        for (int l = 0; l <= D; l++) begin
            for (int i = 0; i <= NUM; i++) begin
                lvl_s[l][i] = '0;
            end
        end
        for (int k = 0; k < NUM; k++) begin
            lvl_s[0][k] = TREE_W'($signed(din[k*DIN_W +: DIN_W]));
        end
        for (int l = 1; l <= D; l++) begin
            for (int i = 0; i <= NUM; i++) begin
                lvl_s[l][i] = node_q[l][i];
            end
        end
    end

    // Pairwise sums; slots past a level's live count stay zero, so an odd leftover passes through.
    always_comb begin
        for (int l = 1; l <= D; l++) begin
            for (int i = 0; i <= NUM; i++) begin
                node_d[l][i] = '0;
            end
        end
        for (int l = 1; l <= D; l++) begin
            for (int i = 0; i < HALF; i++) begin
                node_d[l][i] = lvl_s[l-1][2*i] + lvl_s[l-1][2*i+1];
            end
        end
    end

    // Frame control travels alongside the tree data.
    always_comb begin
        vld_d    = '0;
        fst_d    = '0;
        lst_d    = '0;
        vld_d[1] = din_valid;
        fst_d[1] = din_first;
        lst_d[1] = din_last;
        for (int l = 2; l <= D; l++) begin
            vld_d[l] = vld_q[l-1];
            fst_d[l] = fst_q[l-1];
            lst_d[l] = lst_q[l-1];
        end
    end

    // Accumulate: a first beat restarts the sum, a last beat hands it off and clears acc.
    always_comb begin
        acc_sum_s = (fst_q[D] ? {ACC_W{1'b0}} : acc_q) + ACC_W'(lvl_s[D][0]);
        acc_d     = acc_q;
        fin_d     = fin_q;
        fin_vld_d = 1'b0;
        if (vld_q[D]) begin
            if (lst_q[D]) begin
                acc_d     = '0;
                fin_d     = acc_sum_s;
                fin_vld_d = 1'b1;
            end else begin
                acc_d     = acc_sum_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Output stage: clamp or truncate to OUT_W and flag any overflow.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sat_d        = 1'b0;
        if (fin_vld_q) begin
            dout_valid_d = 1'b1;
            if (SAT_EN) begin
                if (fin_q > OUT_MAX) begin
                    dout_d = OUT_MAX[OUT_W-1:0];
                    sat_d  = 1'b1;
                end else if (fin_q < OUT_MIN) begin
                    dout_d = OUT_MIN[OUT_W-1:0];
                    sat_d  = 1'b1;
                end else begin
                    dout_d = fin_q[OUT_W-1:0];
                end
            end else begin
                dout_d = fin_q[OUT_W-1:0];
                sat_d  = (fin_q > OUT_MAX) || (fin_q < OUT_MIN);
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // Control and result registers, cleared by reset so in-flight beats are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            acc_q        <= '0;
            fin_vld_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            acc_q        <= acc_d;
            fin_vld_q    <= fin_vld_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sat_q        <= sat_d;
        end
    end

    // Datapath registers are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        node_q <= node_d;
        fst_q  <= fst_d;
        lst_q  <= lst_d;
        fin_q  <= fin_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_cal_adder_tree_acc.sv
// Bench for cal_adder_tree_acc: saturating and truncating instances share stimulus
// and are checked every cycle against a frame-level arithmetic reference model.
module tb_cal_adder_tree_acc;

    localparam int NUM   = 36;
    localparam int DIN_W = 16;
    localparam int ACC_W = 24;
    localparam int OUT_W = 18;
    localparam int LAT   = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM*DIN_W-1:0]    din = '0;
    logic                    din_valid = 1'b0;
    logic                    din_first = 1'b0;
    logic                    din_last  = 1'b0;
    logic signed [OUT_W-1:0] dout0, dout1;
    logic                    dout_valid0, dout_valid1, sat0, sat1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    cal_adder_tree_acc #(.SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_first(din_first), .din_last(din_last),
        .dout(dout0), .dout_valid(dout_valid0), .sat_flag(sat0)
    );

    cal_adder_tree_acc #(.SAT_EN(1'b0)) u_trn (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_first(din_first), .din_last(din_last),
        .dout(dout1), .dout_valid(dout_valid1), .sat_flag(sat1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrapn(input longint x, input int n);
        longint m;
        m = x & ((64'sd1 <<< n) - 64'sd1);
        if (m >= (64'sd1 <<< (n - 1))) m = m - (64'sd1 <<< n);
        return m;
    endfunction

    function automatic logic [NUM*DIN_W-1:0] fill(input int v);
        logic [NUM*DIN_W-1:0] r;
        for (int k = 0; k < NUM; k++) r[k*DIN_W +: DIN_W] = 16'(v);
        return r;
    endfunction

    // Reference model: whole frames as plain integer sums, results due LAT cycles after the last beat.
    typedef struct {
        longint due;
        longint d0;
        bit     s0;
        longint d1;
        bit     s1;
    } exp_t;

    exp_t   q[$];
    longint cyc = 0;
    longint acc = 0;
    longint last_d0 = 0, last_d1 = 0;
    bit     exp_vld = 1'b0, exp_s0 = 1'b0, exp_s1 = 1'b0;

    always @(posedge clk) begin
        longint s, hi, lo;
        exp_t   e;
        cyc++;
        exp_vld = 1'b0;
        exp_s0  = 1'b0;
        exp_s1  = 1'b0;
        hi = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (OUT_W - 1));
        if (rst) begin
            q.delete();
            acc     = 0;
            last_d0 = 0;
            last_d1 = 0;
        end else begin
            if (din_valid) begin
                s = 0;
                for (int k = 0; k < NUM; k++) s += longint'($signed(din[k*DIN_W +: DIN_W]));
                acc = wrapn(din_first ? s : acc + s, ACC_W);
                if (din_last) begin
                    e.due = cyc + LAT - 1;
                    e.d0  = (acc > hi) ? hi : (acc < lo) ? lo : acc;
                    e.s0  = (acc > hi) || (acc < lo);
                    e.d1  = wrapn(acc, OUT_W);
                    e.s1  = e.s0;
                    q.push_back(e);
                    acc = 0;
                end
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_vld = 1'b1;
                exp_s0  = e.s0;
                exp_s1  = e.s1;
                last_d0 = e.d0;
                last_d1 = e.d1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_vld0", longint'(dout_valid0), longint'(exp_vld));
            chk("m_dout0", longint'(dout0), last_d0);
            chk("m_sat0", longint'(sat0), longint'(exp_s0));
            chk("m_vld1", longint'(dout_valid1), longint'(exp_vld));
            chk("m_dout1", longint'(dout1), last_d1);
            chk("m_sat1", longint'(sat1), longint'(exp_s1));
        end
    end

    task automatic send(input logic [NUM*DIN_W-1:0] d, input bit f, input bit l);
        din       = d;
        din_valid = 1'b1;
        din_first = f;
        din_last  = l;
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_first = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input string tag, input longint d0, input longint s0,
                                input longint d1, input longint s1);
        int n = 0;
        while (dout_valid0 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_vld"}, longint'(dout_valid0), 1);
        chk({tag, "_d0"}, longint'(dout0), d0);
        chk({tag, "_s0"}, longint'(sat0), s0);
        chk({tag, "_d1"}, longint'(dout1), d1);
        chk({tag, "_s1"}, longint'(sat1), s1);
        idle(1);
    endtask

    initial begin
        logic [NUM*DIN_W-1:0] v;
        int seen;

        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(2);
        chk("rst_dout", longint'(dout0), 0);
        chk("rst_vld", longint'(dout_valid0), 0);
        chk("rst_sat", longint'(sat0), 0);
        rst = 1'b0;
        idle(2);

        // Single beat of ones: result exactly LAT cycles after the beat is presented.
        send(fill(1), 1'b1, 1'b1);
        idle(LAT - 2);
        chk("t1_early", longint'(dout_valid0), 0);
        idle(1);
        chk("t1_vld", longint'(dout_valid0), 1);
        chk("t1_dout", longint'(dout0), 36);
        chk("t1_sat", longint'(sat0), 0);
        idle(1);
        chk("t1_pulse", longint'(dout_valid0), 0);
        chk("t1_hold", longint'(dout0), 36);

        // Three-beat frame with a mid-frame gap.
        send(fill(1), 1'b1, 1'b0);
        idle(2);
        send(fill(1), 1'b0, 1'b0);
        send(fill(1), 1'b0, 1'b1);
        expect_frame("t2", 108, 0, 108, 0);

        // Positive overflow: saturate vs. truncate.
        send(fill(32767), 1'b1, 1'b0);
        send(fill(32767), 1'b0, 1'b0);
        send(fill(32767), 1'b0, 1'b0);
        send(fill(32767), 1'b0, 1'b1);
        expect_frame("t3", 131071, 1, -144, 1);

        // Negative extreme single beat.
        send(fill(-32768), 1'b1, 1'b1);
        expect_frame("t4", -131072, 1, -131072, 1);

        // Mixed signs: +5 on channel 0, -3 elsewhere.
        v = fill(-3);
        for (int k = 0; k < 9; k++) v[k*DIN_W +: DIN_W] = 16'd5;
        send(v, 1'b1, 1'b1);
        expect_frame("t5", -36, 0, -36, 0);

        // Back-to-back single-beat frames.
        send(fill(1), 1'b1, 1'b1);
        send(fill(2), 1'b1, 1'b1);
        send(fill(3), 1'b1, 1'b1);
        expect_frame("t6a", 36, 0, 36, 0);
        chk("t6b_vld", longint'(dout_valid0), 1);
        chk("t6b_dout", longint'(dout0), 72);
        idle(1);
        chk("t6c_vld", longint'(dout_valid0), 1);
        chk("t6c_dout", longint'(dout0), 108);
        idle(2);

        // Reset with a frame in flight drops it.
        send(fill(1), 1'b1, 1'b1);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            seen += int'(dout_valid0);
            idle(1);
        end
        chk("rst_novalid", longint'(seen), 0);
        chk("rst_dout0", longint'(dout0), 0);
        send(fill(1), 1'b1, 1'b1);
        expect_frame("t7", 36, 0, 36, 0);

        // Random beats, gaps, restarts and back-to-back frames, checked by the model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM; k++) v[k*DIN_W +: DIN_W] = 16'($urandom_range(0, 65535));
            din       = v;
            din_valid = ($urandom_range(0, 3) != 0);
            din_first = ($urandom_range(0, 4) == 0);
            din_last  = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        din_first = 1'b0;
        din_last  = 1'b0;
        idle(LAT + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
